// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and settle-count helper for the debouncer
// Purpose: mode/state enumerations and the settle-count computation used by
//          multi_debouncer and debounce_channel.
// Ports:   none (package).
package debounce_pkg;

  typedef enum logic [0:0] {
    MODE_FILTER  = 1'b0,
    MODE_LOCKOUT = 1'b1
  } debounce_mode_e;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2
  } db_state_e;

  // A nonzero simulation count overrides the real-time settle count.
  function automatic int count_max_f(input int sim_count, input int clk_freq,
                                     input int time_delay_ms);
    if (sim_count > 0) begin
      return sim_count;
    end
    return (clk_freq / 1000) * time_delay_ms;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced input channel
// Purpose: 2-flop synchroniser feeding a STABLE/CHECK/HOLD settle FSM.
// Ports:   clk, rst (sync, active-high)
//          value_in   - raw asynchronous input
//          value_out  - debounced level (registered)
//          rise_pulse - one-cycle strobe on value_out 0->1
//          fall_pulse - one-cycle strobe on value_out 1->0
//          busy       - high while in CHECK or HOLD
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int             COUNT_MAX  = 4,
  parameter logic           IDLE_LEVEL = 1'b1,
  parameter debounce_mode_e MODE       = MODE_FILTER
) (
  input  logic clk,
  input  logic rst,
  input  logic value_in,
  output logic value_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = (COUNT_MAX < 1) ? 1 : $clog2(COUNT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT_MAX - 1);

  logic meta_q, sync_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (sync_q != stable_q) begin
          state_d = CHECK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHECK: begin
        if (sync_q == stable_q) begin
          // Glitch: the input went back before the settle time elapsed.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= LAST) begin
          stable_d = ~stable_q;
          rise_d   = ~stable_q;
          fall_d   = stable_q;
          state_d  = (MODE == MODE_LOCKOUT) ? HOLD : STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Post-change lockout: the input is deliberately not looked at.
        if (cnt_q >= LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != STABLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= IDLE_LEVEL;
      sync_q   <= IDLE_LEVEL;
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      meta_q   <= value_in;
      sync_q   <= meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  assign value_out  = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N_CH independent input debouncers
// Purpose: computes the settle count and instantiates one debounce_channel
//          per input bit.
// Ports:   clk, rst (sync, active-high)
//          value_in[N_CH]   - raw asynchronous inputs
//          value_out[N_CH]  - debounced levels
//          rise_pulse[N_CH] - per-channel 0->1 strobes
//          fall_pulse[N_CH] - per-channel 1->0 strobes
//          busy[N_CH]       - per-channel settling/lockout indication
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int             N_CH       = 4,
  parameter int             CLK_FREQ   = 50_000_000,
  parameter int             TIME_DELAY = 500,
  parameter int             SIM_COUNT  = 0,
  parameter logic           IDLE_LEVEL = 1'b1,
  parameter debounce_mode_e MODE       = MODE_FILTER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] value_in,
  output logic [N_CH-1:0] value_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] busy
);

  localparam int COUNT_MAX = count_max_f(SIM_COUNT, CLK_FREQ, TIME_DELAY);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .COUNT_MAX (COUNT_MAX),
      .IDLE_LEVEL(IDLE_LEVEL),
      .MODE      (MODE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .value_in  (value_in[i]),
      .value_out (value_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .busy      (busy[i])
    );
  end

endmodule
